uctl_mem_arb: RTL

Two-port memory arbiter sitting directly downstream of the command-interface memory master. It merges the command-interface memory port and the protocol-engine packet-buffer port onto the single local-memory port. Arbitration is round-robin with one transaction in flight on the request channel. Read data returns in order, and the block routes it back to the requester that issued the read using an ID FIFO.

---
 rtl/uctl_mem_arb_if.sv | 49 ++++
 rtl/uctl_mem_arb.sv | 125 ++++++++++++
 2 files changed

// File: rtl/uctl_mem_arb_if.sv
// Bus bundle for the two-requester memory arbiter: cmd port, pe port and local-memory port.
// slave is the arbiter's view; master is the surrounding environment (requesters plus memory).
interface uctl_mem_arb_if;
    logic        cmd_req;
    logic        cmd_wrRd;
    logic [31:0] cmd_addr;
    logic [31:0] cmd_wrData;
    logic        cmd_ack;
    logic        cmd_rdVal;
    logic [31:0] cmd_rdData;

    logic        pe_req;
    logic        pe_wrRd;
    logic [31:0] pe_addr;
    logic [31:0] pe_wrData;
    logic        pe_ack;
    logic        pe_rdVal;
    logic [31:0] pe_rdData;

    logic        mem_req;
    logic        mem_wrRd;
    logic [31:0] mem_addr;
    logic [31:0] mem_wrData;
    logic        mem_ack;
    logic        mem_rdVal;
    logic [31:0] mem_rdData;

    logic        rd_err;

    modport slave (
        input  cmd_req, cmd_wrRd, cmd_addr, cmd_wrData,
        output cmd_ack, cmd_rdVal, cmd_rdData,
        input  pe_req, pe_wrRd, pe_addr, pe_wrData,
        output pe_ack, pe_rdVal, pe_rdData,
        output mem_req, mem_wrRd, mem_addr, mem_wrData,
        input  mem_ack, mem_rdVal, mem_rdData,
        output rd_err
    );

    modport master (
        output cmd_req, cmd_wrRd, cmd_addr, cmd_wrData,
        input  cmd_ack, cmd_rdVal, cmd_rdData,
        output pe_req, pe_wrRd, pe_addr, pe_wrData,
        input  pe_ack, pe_rdVal, pe_rdData,
        input  mem_req, mem_wrRd, mem_addr, mem_wrData,
        output mem_ack, mem_rdVal, mem_rdData,
        input  rd_err
    );
endinterface

// File: rtl/uctl_mem_arb.sv
// Round-robin arbiter merging cmd and pe ports onto one memory port; one request in flight,
// in-order read returns routed back to the issuer through a small ID FIFO.
module uctl_mem_arb #(
    parameter int RD_OUTSTD = 4
) (
    input  logic           sys_clk,
    input  logic           sysRst_n,
    input  logic           sw_rst,
    uctl_mem_arb_if.slave  bus
);
    localparam int PW = $clog2(RD_OUTSTD);
    localparam int CW = PW + 1;

    typedef enum logic {IDLE, BUSY} state_t;

    state_t          state_q, state_d;
    logic            gnt_q, gnt_d;        // 0 = cmd, 1 = pe
    logic            last_q;
    logic            load;
    logic            wr_q;
    logic [31:0]     addr_q, data_q;

    logic [RD_OUTSTD-1:0] id_mem;
    logic [PW-1:0]   wptr, rptr;
    logic [CW-1:0]   cnt;

    logic rd_ok, cmd_elig, pe_elig, busy, mem_done, push, pop, head, err_q;

    assign rd_ok    = cnt < CW'(RD_OUTSTD);
    assign cmd_elig = bus.cmd_req & (bus.cmd_wrRd | rd_ok);
    assign pe_elig  = bus.pe_req  & (bus.pe_wrRd  | rd_ok);
    assign busy     = (state_q == BUSY);
    assign mem_done = busy & bus.mem_ack;

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        load    = 1'b0;
        case (state_q)
            IDLE: if (cmd_elig | pe_elig) begin
                state_d = BUSY;
                load    = 1'b1;
                // on a tie the requester not granted last wins
                gnt_d   = (cmd_elig & pe_elig) ? ~last_q : pe_elig;
            end
            BUSY: if (bus.mem_ack) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (sw_rst) begin
            state_d = IDLE;
            load    = 1'b0;
        end
    end

    always_ff @(posedge sys_clk or negedge sysRst_n) begin
        if (!sysRst_n) begin
            state_q <= IDLE;
            gnt_q   <= 1'b0;
            last_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            if (sw_rst) begin
                last_q <= 1'b1;
            end else if (load) begin
                gnt_q  <= gnt_d;
                last_q <= gnt_d;
            end
        end
    end

    always_ff @(posedge sys_clk or negedge sysRst_n) begin
        if (!sysRst_n) begin
            wr_q   <= 1'b0;
            addr_q <= '0;
            data_q <= '0;
        end else if (load) begin
            wr_q   <= gnt_d ? bus.pe_wrRd   : bus.cmd_wrRd;
            addr_q <= gnt_d ? bus.pe_addr   : bus.cmd_addr;
            data_q <= gnt_d ? bus.pe_wrData : bus.cmd_wrData;
        end
    end

    assign push = mem_done & ~wr_q;
    assign pop  = bus.mem_rdVal & (cnt != '0);
    assign head = id_mem[rptr];

    always_ff @(posedge sys_clk or negedge sysRst_n) begin
        if (!sysRst_n) begin
            id_mem <= '0;
            wptr   <= '0;
            rptr   <= '0;
            cnt    <= '0;
        end else if (sw_rst) begin
            wptr <= '0;
            rptr <= '0;
            cnt  <= '0;
        end else begin
            if (push) begin
                id_mem[wptr] <= gnt_q;
                wptr         <= wptr + PW'(1);
            end
            if (pop) rptr <= rptr + PW'(1);
            if (push && !pop)      cnt <= cnt + CW'(1);
            else if (pop && !push) cnt <= cnt - CW'(1);
        end
    end

    always_ff @(posedge sys_clk or negedge sysRst_n) begin
        if (!sysRst_n)                       err_q <= 1'b0;
        else if (sw_rst)                     err_q <= 1'b0;
        else if (bus.mem_rdVal && cnt == '0) err_q <= 1'b1;
    end

    assign bus.mem_req    = busy;
    assign bus.mem_wrRd   = wr_q;
    assign bus.mem_addr   = addr_q;
    assign bus.mem_wrData = data_q;
    assign bus.cmd_ack    = mem_done & ~gnt_q;
    assign bus.pe_ack     = mem_done &  gnt_q;
    assign bus.cmd_rdVal  = pop & ~head;
    assign bus.pe_rdVal   = pop &  head;
    assign bus.cmd_rdData = bus.mem_rdData;
    assign bus.pe_rdData  = bus.mem_rdData;
    assign bus.rd_err     = err_q;
endmodule
